serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Serialiser feeding the link receiver's S_Data input. Accepts 32-bit words from the core via
//  valid/ready handshake; emits preamble, bit-stuffed MSB-first data, and odd parity on one line.
//  Idle line is 1. Honours receiver flow control (Rx_Ready) at packet start.
// PARAMETERS
//  DATA_WIDTH    32  payload bits per packet
//  PREAMBLE_LEN  5   consecutive 0s opening each packet (never stuffed)
//  STUFF_RUN     4   after this many consecutive payload/parity 0s, insert one stuffed 1
//  GAP_LEN       2   minimum idle (1) bit times between packets
// PORTS
//  Clk_s          in   1           system clock; one serial bit per cycle
//  Rst            in   1           asynchronous reset, active-high
//  TxData         in   DATA_WIDTH  word from core
//  TxData_Valid   in   1           core offers TxData
//  Tx_Ready       out  1           block can accept a word this cycle
//  Rx_Ready       in   1           receiver able to take a packet
//  S_Data         out  1           serial line (registered)
//  Tx_Busy        out  1           packet in flight (PREAMBLE..GAP)
// BEHAVIOUR
//  Reset (async, immediate): S_Data=1, Tx_Ready=0 during reset and 1 on the first clock after
//   release, Tx_Busy=0, FSM=IDLE, shift reg/counters/buffer cleared. Mid-packet reset aborts packet.
//  Accept: word taken on rising Clk_s when TxData_Valid && Tx_Ready; TxData is captured into the
//   shift register and the parity bit is latched the same edge.
//  Tx_Ready = (FSM==IDLE) with no buffer held.
//  FSM: IDLE -> PREAMBLE when a word is held && Rx_Ready; Rx_Ready low holds IDLE with S_Data=1.
//   PREAMBLE: PREAMBLE_LEN cycles S_Data=0 -> DATA.
//   DATA: DATA_WIDTH payload bits MSB first plus stuffed bits -> PARITY.
//   PARITY: 1 bit plus a stuff bit if required -> GAP.
//   GAP: GAP_LEN cycles S_Data=1 -> IDLE.
//   Rx_Ready is sampled only in IDLE; once started a packet always completes.
//  Latency: word accepted at edge N with Rx_Ready=1 -> first preamble 0 on S_Data after edge N+1.
//  Stuffing: zero-run counter cleared entering DATA and on every emitted 1. When it reaches
//   STUFF_RUN, the next bit time emits a 1, the shift register holds, and the counter clears.
//   Applies to payload and parity; preamble and gap bits are not counted.
//  Parity: odd; parity bit = ~^TxData, so total 1s in payload+parity is odd. Stuffed bits excluded.
//  Packet length = PREAMBLE_LEN + DATA_WIDTH + 1 + n_stuff bit times, then GAP.
//  Simultaneous: a Valid arriving while Tx_Ready=0 is ignored; the core must hold it.
// CONFIGURATION
//  TX_BUF2_EN defined: adds one holding register. Tx_Ready = !buffer_full, so a second word is
//   accepted while a packet is in flight. At the end of GAP, the next packet starts with no extra
//   idle beyond GAP_LEN (if Rx_Ready). A full buffer plus active packet drops Tx_Ready.
//  TX_BUF2_EN undefined: single word; Tx_Ready only in IDLE with nothing held.
//   Port list is identical in both builds.
// TESTING
//  1 Rst high 2 cycles then low -> S_Data=1, Tx_Busy=0, Tx_Ready=1 the cycle after release.
//  2 TxData=32'h5555_5555, Rx_Ready=1 -> S_Data: 00000, then 0101..01 (32 bits), then parity 1;
//    38 bits, no stuffing, then 2 idle 1s.
//  3 TxData=32'h0000_0000 -> 00000, then 8 groups of (0000 1), then parity 1;
//    46-bit packet; the stuff after bit 31 precedes parity.
//  4 TxData=32'h0000_0001 -> parity 0; 31 zeros yield 7 stuffs (after the 28th zero), then
//    "0001", then parity 0. Verify a 0-run of 4 before parity does not trigger a stuff
//    unless reached.
//  5 Rx_Ready=0 with word held for 10 cycles -> S_Data stays 1, Tx_Ready=0.
//    Raise Rx_Ready -> preamble starts the next cycle.
//  6 Rst asserted mid-DATA -> S_Data=1 immediately, FSM IDLE, buffer empty.
//    With TX_BUF2_EN: two back-to-back words -> exactly GAP_LEN 1s between packets.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: serialises words from the core onto a single line.
//   Each packet is PREAMBLE_LEN zeros, DATA_WIDTH payload bits MSB first, then one odd-parity bit.
//   After every STUFF_RUN consecutive payload/parity zeros, one stuffed 1 is inserted.
//   The packet is followed by GAP_LEN idle ones. The idle line level is 1.
// Ports:
//   Clk_s        in   system clock, one serial bit per cycle
//   Rst          in   asynchronous reset, active-high
//   TxData       in   word from core
//   TxData_Valid in   core offers TxData
//   Tx_Ready     out  a word can be accepted this cycle
//   Rx_Ready     in   receiver can take a packet (sampled only when a packet could start)
//   S_Data       out  registered serial line
//   Tx_Busy      out  packet in flight (preamble through gap)
// Build option: define TX_BUF2_EN to add a one-word holding buffer, so the next word can be
//   accepted while a packet is in flight and can follow the gap directly.
module serial_tx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned PREAMBLE_LEN = 5,
    parameter int unsigned STUFF_RUN    = 4,
    parameter int unsigned GAP_LEN      = 2
) (
    input  logic                  Clk_s,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  TxData_Valid,
    output logic                  Tx_Ready,
    input  logic                  Rx_Ready,
    output logic                  S_Data,
    output logic                  Tx_Busy
);

    localparam int unsigned CntW  = $clog2(DATA_WIDTH + PREAMBLE_LEN + GAP_LEN + 1);
    localparam int unsigned ZrunW = $clog2(STUFF_RUN + 1);

    localparam logic [CntW-1:0]  PreCnt  = CntW'(PREAMBLE_LEN);
    localparam logic [CntW-1:0]  DataCnt = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0]  GapCnt  = CntW'(GAP_LEN);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);
    localparam logic [ZrunW-1:0] RunMax  = ZrunW'(STUFF_RUN);
    localparam logic [ZrunW-1:0] RunOne  = ZrunW'(1);

    typedef enum logic [2:0] {StIdle, StPreamble, StData, StParity, StGap} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;      // bits emitted so far in the current phase
    logic [ZrunW-1:0]      zrun_q, zrun_d;    // consecutive counted zeros, including S_Data
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  s_data_q, s_data_d;
    logic                  rdy_en_q;          // keeps Tx_Ready low until the first clock after reset

    logic accept;
    logic start_pkt;
    logic emit_data;
    logic emit_par;
    logic word_held;
    logic tx_bit;

`ifdef TX_BUF2_EN
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_par_q, buf_par_d;
    logic                  buf_full_q, buf_full_d;
    assign word_held = buf_full_q;
`else
    logic held_q, held_d;  // shift_q holds a word that has not started yet
    assign word_held = held_q;
`endif

    assign accept = TxData_Valid & Tx_Ready;

    // State register
    always_ff @(posedge Clk_s or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zrun_d    = zrun_q;
        shift_d   = shift_q;
        par_d     = par_q;
        s_data_d  = 1'b1;
        start_pkt = 1'b0;
        emit_data = 1'b0;
        emit_par  = 1'b0;
        tx_bit    = 1'b1;
`ifdef TX_BUF2_EN
        buf_d      = buf_q;
        buf_par_d  = buf_par_q;
        buf_full_d = buf_full_q;
`else
        held_d = held_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (word_held && Rx_Ready) begin
                    start_pkt = 1'b1;
                end
            end
            StPreamble: begin
                if (cnt_q < PreCnt) begin
                    s_data_d = 1'b0;
                    cnt_d    = cnt_q + CntOne;
                end else begin
                    state_d   = StData;
                    cnt_d     = '0;
                    zrun_d    = '0;
                    emit_data = 1'b1;
                end
            end
            StData: begin
                if (zrun_q == RunMax) begin
                    // Stuffed 1: shift register holds
                    zrun_d = '0;
                end else if (cnt_q < DataCnt) begin
                    emit_data = 1'b1;
                end else begin
                    state_d  = StParity;
                    emit_par = 1'b1;
                end
            end
            StParity: begin
                if (zrun_q == RunMax) begin
                    zrun_d = '0;
                end else begin
                    state_d = StGap;
                    cnt_d   = CntOne;
                end
            end
            StGap: begin
                if (cnt_q < GapCnt) begin
                    cnt_d = cnt_q + CntOne;
                end else if (word_held && Rx_Ready) begin
                    // Back-to-back: next preamble follows the gap directly
                    start_pkt = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_pkt) begin
            state_d  = StPreamble;
            cnt_d    = CntOne;
            s_data_d = 1'b0;
`ifdef TX_BUF2_EN
            shift_d    = buf_q;
            par_d      = buf_par_q;
            buf_full_d = 1'b0;
`else
            held_d = 1'b0;
`endif
        end

        if (emit_data) begin
            tx_bit  = shift_q[DATA_WIDTH-1];
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_d + CntOne;
        end else if (emit_par) begin
            tx_bit = par_q;
        end

        if (emit_data || emit_par) begin
            s_data_d = tx_bit;
            zrun_d   = tx_bit ? '0 : zrun_d + RunOne;
        end

        if (accept) begin
`ifdef TX_BUF2_EN
            buf_d      = TxData;
            buf_par_d  = ~^TxData;
            buf_full_d = 1'b1;
`else
            shift_d = TxData;
            par_d   = ~^TxData;
            held_d  = 1'b1;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge Clk_s or posedge Rst) begin
        if (Rst) begin
            cnt_q    <= '0;
            zrun_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            s_data_q <= 1'b1;
            rdy_en_q <= 1'b0;
`ifdef TX_BUF2_EN
            buf_q      <= '0;
            buf_par_q  <= 1'b0;
            buf_full_q <= 1'b0;
`else
            held_q <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            zrun_q   <= zrun_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            s_data_q <= s_data_d;
            rdy_en_q <= 1'b1;
`ifdef TX_BUF2_EN
            buf_q      <= buf_d;
            buf_par_q  <= buf_par_d;
            buf_full_q <= buf_full_d;
`else
            held_q <= held_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        S_Data  = s_data_q;
        Tx_Busy = (state_q != StIdle);
`ifdef TX_BUF2_EN
        Tx_Ready = rdy_en_q & ~buf_full_q;
`else
        Tx_Ready = rdy_en_q & (state_q == StIdle) & ~held_q;
`endif
    end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

    logic        Clk_s        = 1'b0;
    logic        Rst          = 1'b0;
    logic [31:0] TxData       = '0;
    logic        TxData_Valid = 1'b0;
    logic        Rx_Ready     = 1'b1;
    logic        Tx_Ready;
    logic        S_Data;
    logic        Tx_Busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic sd;
        logic busy;
        logic rdy;
    } exp_t;

    exp_t exp_q[$];

    serial_tx dut (
        .Clk_s        (Clk_s),
        .Rst          (Rst),
        .TxData       (TxData),
        .TxData_Valid (TxData_Valid),
        .Tx_Ready     (Tx_Ready),
        .Rx_Ready     (Rx_Ready),
        .S_Data       (S_Data),
        .Tx_Busy      (Tx_Busy)
    );

    always #5 Clk_s = ~Clk_s;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input logic sd, input logic busy, input logic rdy);
        exp_t e;
        e.sd   = sd;
        e.busy = busy;
        e.rdy  = rdy;
        exp_q.push_back(e);
    endtask

    // Reference stream for one packet, one entry per bit time, sampled between edges
    task automatic push_packet(input logic [31:0] w, input bit lead, input bit trail);
        int   run;
        logic b;
        logic rdy_pkt;
`ifdef TX_BUF2_EN
        rdy_pkt = 1'b1;
`else
        rdy_pkt = 1'b0;
`endif
        run = 0;
        if (lead) push_exp(1'b1, 1'b0, 1'b0);
        repeat (5) push_exp(1'b0, 1'b1, rdy_pkt);
        for (int i = 31; i >= -1; i--) begin
            b = (i >= 0) ? w[i] : ~^w;
            push_exp(b, 1'b1, rdy_pkt);
            run = b ? 0 : run + 1;
            if (run == 4) begin
                push_exp(1'b1, 1'b1, rdy_pkt);
                run = 0;
            end
        end
        repeat (2) push_exp(1'b1, 1'b1, rdy_pkt);
        if (trail) push_exp(1'b1, 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input string nm);
        int budget;
        budget = 200;
        while (Tx_Ready !== 1'b1 && budget > 0) begin
            @(negedge Clk_s);
            budget--;
        end
        total++;
        if (Tx_Ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_wait: Tx_Ready=%b required 1", nm, Tx_Ready);
        end
        TxData       = w;
        TxData_Valid = 1'b1;
        @(negedge Clk_s);
        TxData_Valid = 1'b0;
    endtask

    // Scoreboard consumer: pops one expected entry per bit time
    task automatic drain(input string nm, input bit chk_rdy, output int busy_n);
        exp_t e;
        int   idx;
        idx    = 0;
        busy_n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (Tx_Busy === 1'b1) busy_n++;
            total++;
            if (S_Data !== e.sd || Tx_Busy !== e.busy || (chk_rdy && Tx_Ready !== e.rdy)) begin
                bad++;
                $display("FAIL %s_bit%0d: S_Data=%b Tx_Busy=%b Tx_Ready=%b required %b %b %b",
                         nm, idx, S_Data, Tx_Busy, Tx_Ready, e.sd, e.busy, e.rdy);
            end
            idx++;
            @(negedge Clk_s);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        #1 Rst = 1'b1;
        repeat (2) @(posedge Clk_s);
        @(negedge Clk_s);
        total++;
        if (S_Data !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: S_Data=%b Tx_Busy=%b Tx_Ready=%b required 1 0 0",
                     S_Data, Tx_Busy, Tx_Ready);
        end
        Rst = 1'b0;
        #1;
        total++;
        if (Tx_Ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready: Tx_Ready=%b required 0", Tx_Ready);
        end
        @(negedge Clk_s);
        total++;
        if (S_Data !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_clock: S_Data=%b Tx_Busy=%b Tx_Ready=%b required 1 0 1",
                     S_Data, Tx_Busy, Tx_Ready);
        end
    endtask

    task automatic test_pattern(input logic [31:0] w, input int exp_busy, input string nm);
        int busy_n;
        push_packet(w, 1'b1, 1'b1);
        send_word(w, nm);
        drain(nm, 1'b1, busy_n);
        if (exp_busy > 0) begin
            total++;
            if (busy_n != exp_busy) begin
                bad++;
                $display("FAIL %s_length: busy cycles=%0d required %0d", nm, busy_n, exp_busy);
            end
        end
    endtask

    task automatic test_rx_hold;
        logic [31:0] w;
        int          busy_n;
        w        = 32'hA5A5_0F00;
        Rx_Ready = 1'b0;
        send_word(w, "rxhold");
        for (int i = 0; i < 10; i++) begin
            total++;
            if (S_Data !== 1'b1 || Tx_Ready !== 1'b0 || Tx_Busy !== 1'b0) begin
                bad++;
                $display("FAIL rxhold_cycle%0d: S_Data=%b Tx_Ready=%b Tx_Busy=%b required 1 0 0",
                         i, S_Data, Tx_Ready, Tx_Busy);
            end
            @(negedge Clk_s);
        end
        Rx_Ready = 1'b1;
        push_packet(w, 1'b0, 1'b1);
        @(negedge Clk_s);
        drain("rxhold", 1'b1, busy_n);
    endtask

    task automatic test_mid_reset;
        send_word(32'h0000_0000, "midrst");
        repeat (15) @(negedge Clk_s);
        total++;
        if (Tx_Busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_inflight: Tx_Busy=%b required 1", Tx_Busy);
        end
        #2 Rst = 1'b1;
        #1;
        total++;
        if (S_Data !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_abort: S_Data=%b Tx_Busy=%b Tx_Ready=%b required 1 0 0",
                     S_Data, Tx_Busy, Tx_Ready);
        end
        @(negedge Clk_s);
        Rst = 1'b0;
        @(negedge Clk_s);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (S_Data !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Ready !== 1'b1) begin
                bad++;
                $display("FAIL midrst_idle%0d: S_Data=%b Tx_Busy=%b Tx_Ready=%b required 1 0 1",
                         i, S_Data, Tx_Busy, Tx_Ready);
            end
            @(negedge Clk_s);
        end
    endtask

`ifdef TX_BUF2_EN
    task automatic test_back_to_back;
        logic [31:0] w1;
        logic [31:0] w2;
        int          busy_n;
        w1 = 32'h0000_0001;
        w2 = 32'hF0F0_1234;
        push_packet(w1, 1'b1, 1'b0);
        push_packet(w2, 1'b0, 1'b1);
        send_word(w1, "b2b_first");
        fork
            drain("b2b", 1'b0, busy_n);
            begin
                repeat (3) @(negedge Clk_s);
                total++;
                if (Tx_Ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_inflight: Tx_Ready=%b required 1", Tx_Ready);
                end
                TxData       = w2;
                TxData_Valid = 1'b1;
                @(negedge Clk_s);
                TxData_Valid = 1'b0;
                total++;
                if (Tx_Ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_ready_full: Tx_Ready=%b required 0", Tx_Ready);
                end
            end
        join
    endtask
`endif

    initial begin
        test_reset();
        test_pattern(32'h5555_5555, 40, "p5555");
        test_pattern(32'h0000_0000, 48, "pzero");
        test_pattern(32'h0000_0001, 47, "pone");
        test_pattern(32'h8000_0000, 48, "pstuffpar");
        test_pattern(32'hFFFF_FFFF, 40, "pones");
        test_pattern($urandom, 0, "prand0");
        test_pattern($urandom, 0, "prand1");
        test_rx_hold();
        test_mid_reset();
`ifdef TX_BUF2_EN
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
